// File: rtl/uart_packet_parser_if.sv
// Byte-stream input and assembled-packet output bundle for the UART packet parser.
// master = byte producer / packet consumer side, slave = the parser.
interface uart_packet_parser_if #(
    parameter int MAX_LEN = 8
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    logic [7:0]           in_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [7:0]           cmd_out;
    logic [LEN_W-1:0]     len_out;
    logic [8*MAX_LEN-1:0] payload_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 err_checksum;
    logic                 err_length;
    logic                 err_timeout;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, cmd_out, len_out, payload_out, out_valid,
               err_checksum, err_length, err_timeout
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, cmd_out, len_out, payload_out, out_valid,
               err_checksum, err_length, err_timeout
    );
endinterface

// File: rtl/uart_packet_parser.sv
// Frames UART bytes into SYNC/CMD/LEN/PAYLOAD/XOR packets, holds each good packet
// until consumed, and pulses an error flag for length, checksum or timeout faults.
module uart_packet_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hAA,
    parameter int         MAX_LEN        = 8,
    parameter int         TIMEOUT_CYCLES = 5_000_000
) (
    input logic                clk,
    input logic                rst,
    uart_packet_parser_if.slave bus
);
    localparam int LEN_W = $clog2(MAX_LEN + 1);
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CHECK   = 3'd4,
        ST_HOLD    = 3'd5
    } state_t;

    state_t               state_r;
    logic [7:0]           cmd_r;
    logic [7:0]           chk_r;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     idx_r;
    logic [8*MAX_LEN-1:0] payload_r;
    logic [TMO_W-1:0]     tmo_cnt_r;
    logic                 out_valid_r;
    logic                 err_checksum_r;
    logic                 err_length_r;
    logic                 err_timeout_r;
    logic                 accept_s;
    logic                 timed_s;

    function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
        return acc ^ b;
    endfunction

    assign accept_s = bus.in_valid && (state_r != ST_HOLD);
    assign timed_s  = (state_r == ST_CMD) || (state_r == ST_LEN) ||
                      (state_r == ST_PAYLOAD) || (state_r == ST_CHECK);

    assign bus.in_ready     = (state_r != ST_HOLD);
    assign bus.cmd_out      = cmd_r;
    assign bus.len_out      = len_r;
    assign bus.payload_out  = payload_r;
    assign bus.out_valid    = out_valid_r;
    assign bus.err_checksum = err_checksum_r;
    assign bus.err_length   = err_length_r;
    assign bus.err_timeout  = err_timeout_r;

    // Frame FSM, inter-byte timeout counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            cmd_r          <= 8'h00;
            chk_r          <= 8'h00;
            len_r          <= '0;
            idx_r          <= '0;
            payload_r      <= '0;
            tmo_cnt_r      <= '0;
            out_valid_r    <= 1'b0;
            err_checksum_r <= 1'b0;
            err_length_r   <= 1'b0;
            err_timeout_r  <= 1'b0;
        end else begin
            err_checksum_r <= 1'b0;
            err_length_r   <= 1'b0;
            err_timeout_r  <= 1'b0;

            // An accepted byte always restarts the idle count, so it beats an expiring timer.
            if (timed_s && !accept_s) begin
                if (tmo_cnt_r == TMO_LAST) begin
                    err_timeout_r <= 1'b1;
                    state_r       <= ST_IDLE;
                    tmo_cnt_r     <= '0;
                end else begin
                    tmo_cnt_r <= tmo_cnt_r + TMO_W'(1);
                end
            end else begin
                tmo_cnt_r <= '0;
            end

            case (state_r)
                ST_IDLE: begin
                    if (accept_s && (bus.in_data == SYNC_BYTE)) begin
                        payload_r <= '0;
                        chk_r     <= 8'h00;
                        state_r   <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (accept_s) begin
                        cmd_r   <= bus.in_data;
                        chk_r   <= bus.in_data;
                        state_r <= ST_LEN;
                    end
                end
                ST_LEN: begin
                    if (accept_s) begin
                        if (bus.in_data > 8'(MAX_LEN)) begin
                            err_length_r <= 1'b1;
                            state_r      <= ST_IDLE;
                        end else begin
                            len_r   <= bus.in_data[LEN_W-1:0];
                            chk_r   <= chk_update(chk_r, bus.in_data);
                            idx_r   <= '0;
                            state_r <= (bus.in_data == 8'h00) ? ST_CHECK : ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    if (accept_s) begin
                        for (int i = 0; i < MAX_LEN; i++) begin
                            if (idx_r == LEN_W'(i)) begin
                                payload_r[8*i +: 8] <= bus.in_data;
                            end
                        end
                        chk_r <= chk_update(chk_r, bus.in_data);
                        idx_r <= idx_r + LEN_W'(1);
                        if ((idx_r + LEN_W'(1)) == len_r) begin
                            state_r <= ST_CHECK;
                        end
                    end
                end
                ST_CHECK: begin
                    if (accept_s) begin
                        if (bus.in_data == chk_r) begin
                            out_valid_r <= 1'b1;
                            state_r     <= ST_HOLD;
                        end else begin
                            err_checksum_r <= 1'b1;
                            state_r        <= ST_IDLE;
                        end
                    end
                end
                ST_HOLD: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        state_r     <= ST_IDLE;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_packet_parser.sv
// Self-checking bench for uart_packet_parser: vector table, hand-written corner
// sequences and randomized frames checked against a frame-level reference model.
module tb_uart_packet_parser;
    localparam int MAX_LEN = 8;
    localparam int TMO     = 100;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    uart_packet_parser_if #(.MAX_LEN(MAX_LEN)) bus ();

    uart_packet_parser #(
        .SYNC_BYTE      (8'hAA),
        .MAX_LEN        (MAX_LEN),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: count error-pulse cycles and capture each packet on out_valid rise.
    int          n_err_chk;
    int          n_err_len;
    int          n_err_tmo;
    int          n_got;
    logic [7:0]  got_cmd [256];
    logic [3:0]  got_len [256];
    logic [63:0] got_pl  [256];
    logic        ov_prev;

    initial begin
        n_err_chk = 0;
        n_err_len = 0;
        n_err_tmo = 0;
        n_got     = 0;
        ov_prev   = 1'b0;
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.err_checksum) n_err_chk = n_err_chk + 1;
            if (bus.err_length)   n_err_len = n_err_len + 1;
            if (bus.err_timeout)  n_err_tmo = n_err_tmo + 1;
            if (bus.out_valid && !ov_prev && n_got < 256) begin
                got_cmd[n_got] = bus.cmd_out;
                got_len[n_got] = bus.len_out;
                got_pl[n_got]  = bus.payload_out;
                n_got = n_got + 1;
            end
            ov_prev = bus.out_valid;
        end else begin
            ov_prev = 1'b0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        int guard;
        guard = 0;
        @(negedge clk);
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && guard < 1000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 1000) check("send_timeout", 64'(guard), 64'(0));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Compares everything observed since the snapshot (g0, c0, l0, t0) with the expected frame outcome.
    task automatic check_frame(input string tag, input int g0, input int c0, input int l0, input int t0,
                               input bit exp_pkt, input logic [7:0] ecmd, input logic [3:0] elen,
                               input logic [63:0] epl, input int echk, input int elerr);
        check({tag, "_npkt"}, 64'(n_got - g0), 64'(exp_pkt));
        if (exp_pkt && n_got > g0) begin
            check({tag, "_cmd"}, 64'(got_cmd[g0]), 64'(ecmd));
            check({tag, "_len"}, 64'(got_len[g0]), 64'(elen));
            check({tag, "_payload"}, got_pl[g0], epl);
        end
        check({tag, "_err_chk"}, 64'(n_err_chk - c0), 64'(echk));
        check({tag, "_err_len"}, 64'(n_err_len - l0), 64'(elerr));
        check({tag, "_err_tmo"}, 64'(n_err_tmo - t0), 64'(0));
    endtask

    typedef struct {
        logic [95:0] b;      // bytes, first byte in the most significant used position
        int          n;
        bit          pkt;
        logic [7:0]  cmd;
        logic [3:0]  len;
        logic [63:0] pl;
        int          e_chk;
        int          e_len;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int g0, c0, l0, t0, guard;
        bit stable;
        logic [7:0]  s_cmd;
        logic [3:0]  s_len;
        logic [63:0] s_pl;

        n_tests = 0;
        n_fail  = 0;

        vecs[0] = '{96'hAA1002050611, 6, 1'b1, 8'h10, 4'd2, 64'h0605, 0, 0};
        vecs[1] = '{96'h55AA200020, 5, 1'b1, 8'h20, 4'd0, 64'h0, 0, 0};
        vecs[2] = '{96'hAA10013300, 5, 1'b0, 8'h00, 4'd0, 64'h0, 1, 0};
        vecs[3] = '{96'hAA1002050611, 6, 1'b1, 8'h10, 4'd2, 64'h0605, 0, 0};
        vecs[4] = '{96'hAA1009, 3, 1'b0, 8'h00, 4'd0, 64'h0, 0, 1};
        vecs[5] = '{96'hAA300030, 4, 1'b1, 8'h30, 4'd0, 64'h0, 0, 0};
        vecs[6] = '{96'hAA0108010203040506070801, 12, 1'b1, 8'h01, 4'd8, 64'h0807060504030201, 0, 0};
        vecs[7] = '{96'hAA0501AAAE, 5, 1'b1, 8'h05, 4'd1, 64'hAA, 0, 0};

        rst           = 1'b1;
        bus.in_data   = 8'h00;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 64'(bus.in_ready), 64'(1));
        check("rst_out_valid", 64'(bus.out_valid), 64'(0));
        check("rst_cmd", 64'(bus.cmd_out), 64'(0));
        check("rst_len", 64'(bus.len_out), 64'(0));
        check("rst_payload", bus.payload_out, 64'h0);
        check("rst_errs", 64'({bus.err_checksum, bus.err_length, bus.err_timeout}), 64'(0));
        rst = 1'b0;

        for (int v = 0; v < 8; v++) begin
            g0 = n_got; c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].b[8*(vecs[v].n-1-i) +: 8]);
            end
            settle();
            check_frame($sformatf("vec%0d", v), g0, c0, l0, t0, vecs[v].pkt, vecs[v].cmd,
                        vecs[v].len, vecs[v].pl, vecs[v].e_chk, vecs[v].e_len);
        end

        // Timeout after AA 10 and exactly TMO idle cycles, then recovery.
        t0 = n_err_tmo;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (TMO - 1) @(posedge clk);
        #1;
        check("tmo_early", 64'(n_err_tmo - t0), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        check("tmo_pulse", 64'(n_err_tmo - t0), 64'(1));
        repeat (10) @(posedge clk);
        check("tmo_single", 64'(n_err_tmo - t0), 64'(1));
        g0 = n_got; c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h00); send_byte(8'h10);
        settle();
        check_frame("tmo_recover", g0, c0, l0, t0, 1'b1, 8'h10, 4'd0, 64'h0, 0, 0);

        // A byte landing on the expiring cycle wins over the timeout.
        g0 = n_got; c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
        send_byte(8'hAA);
        send_byte(8'h10);
        repeat (TMO - 1) @(posedge clk);
        send_byte(8'h00);
        send_byte(8'h10);
        settle();
        check_frame("tmo_race", g0, c0, l0, t0, 1'b1, 8'h10, 4'd0, 64'h0, 0, 0);

        // Backpressure: hold 20 cycles, then release with a byte already waiting.
        g0 = n_got;
        bus.out_ready = 1'b0;
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h11);
        check("bp_latency", 64'(bus.out_valid), 64'(1));
        guard = 0;
        while (!bus.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        s_cmd = bus.cmd_out; s_len = bus.len_out; s_pl = bus.payload_out;
        check("bp_snap", {s_pl[15:0], s_cmd, 4'h0, s_len}, {16'h0605, 8'h10, 4'h0, 4'd2});
        stable = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1 || bus.cmd_out !== s_cmd ||
                bus.len_out !== s_len || bus.payload_out !== s_pl) stable = 1'b0;
        end
        check("bp_stable", 64'(stable), 64'(1));
        @(negedge clk);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'hAA;
        @(negedge clk);
        check("bp_drop", 64'(bus.out_valid), 64'(0));
        check("bp_ready_back", 64'(bus.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        send_byte(8'h30); send_byte(8'h00); send_byte(8'h30);
        settle();
        check("bp_npkt", 64'(n_got - g0), 64'(2));
        if (n_got >= g0 + 2) check("bp_next_cmd", 64'(got_cmd[g0+1]), 64'(8'h30));

        // Reset mid-frame aborts silently.
        c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02); send_byte(8'h05);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_outs", {bus.payload_out[55:0], bus.cmd_out},
              {56'h0, 8'h00});
        check("mid_rst_len_valid", 64'({bus.len_out, bus.out_valid, bus.in_ready}), 64'({4'd0, 1'b0, 1'b1}));
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_noerr", 64'((n_err_chk - c0) + (n_err_len - l0) + (n_err_tmo - t0)), 64'(0));
        g0 = n_got; c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
        send_byte(8'hAA); send_byte(8'h10); send_byte(8'h02);
        send_byte(8'h05); send_byte(8'h06); send_byte(8'h11);
        settle();
        check_frame("after_rst", g0, c0, l0, t0, 1'b1, 8'h10, 4'd2, 64'h0605, 0, 0);

        // Random frames; expectations come from how each frame was constructed.
        for (int f = 0; f < 40; f++) begin
            logic [7:0]  q [$];
            logic [7:0]  cmd, len, chk, g, p;
            logic [63:0] epl;
            int          mode;
            bit          epkt;
            int          echk, elerr;
            q.delete();
            for (int k = 0; k < int'($urandom_range(0, 2)); k++) begin
                g = 8'($urandom_range(0, 254));
                if (g == 8'hAA) g = 8'h55;
                q.push_back(g);
            end
            mode = int'($urandom_range(0, 9));
            cmd  = 8'($urandom_range(0, 255));
            q.push_back(8'hAA);
            q.push_back(cmd);
            epl = 64'h0; epkt = 1'b0; echk = 0; elerr = 0;
            if (mode == 0) begin
                len = 8'($urandom_range(MAX_LEN + 1, 255));
                q.push_back(len);
                elerr = 1;
            end else begin
                len = 8'($urandom_range(0, MAX_LEN));
                q.push_back(len);
                chk = cmd ^ len;
                for (int k = 0; k < int'(len); k++) begin
                    p = 8'($urandom_range(0, 255));
                    q.push_back(p);
                    chk = chk ^ p;
                    epl[8*k +: 8] = p;
                end
                if (mode <= 2) begin
                    q.push_back(chk ^ 8'($urandom_range(1, 255)));
                    echk = 1;
                end else begin
                    q.push_back(chk);
                    epkt = 1'b1;
                end
            end
            g0 = n_got; c0 = n_err_chk; l0 = n_err_len; t0 = n_err_tmo;
            foreach (q[k]) begin
                send_byte(q[k]);
                repeat ($urandom_range(0, 3)) @(posedge clk);
            end
            settle();
            check_frame($sformatf("rnd%0d", f), g0, c0, l0, t0, epkt, cmd, len[3:0], epl, echk, elerr);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_packet_parser.md
Name: uart_packet_parser

Overview:
- Consumes the received byte stream from the Arduino UART receive buffer over a valid/ready handshake.
- Frames bytes into command packets: sync byte, command, length, payload, XOR checksum.
- Presents each good packet, fully assembled, on a valid/ready output port for the command-handling logic.
- Flags malformed packets (bad length, bad checksum, inter-byte timeout) with single-cycle error pulses.

Parameters:
- SYNC_BYTE, 8'hAA: frame start marker.
- MAX_LEN, 8: maximum payload bytes per packet.
- TIMEOUT_CYCLES, 5_000_000: idle cycles allowed between bytes inside a frame (100 ms at 50 MHz).

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-high reset
- in_data  input  8  byte from UART receive buffer
- in_valid  input  1  in_data is valid
- in_ready  output  1  parser accepts a byte this cycle
- cmd_out  output  8  command byte of the held packet
- len_out  output  $clog2(MAX_LEN+1)  payload length of the held packet
- payload_out  output  8*MAX_LEN  payload; byte i occupies bits [8i+7:8i]
- out_valid  output  1  packet held on the outputs
- out_ready  input  1  consumer takes the packet
- err_checksum  output  1  1-cycle pulse: checksum mismatch
- err_length  output  1  1-cycle pulse: length > MAX_LEN
- err_timeout  output  1  1-cycle pulse: inter-byte timeout

Behaviour:
- Byte acceptance: a byte is accepted on a rising clk when in_valid && in_ready.
- in_ready is combinational: in_ready = (state != HOLD).
- Reset values: state=IDLE; in_ready=1; out_valid=0; cmd_out=0; len_out=0; payload_out=0; all err_* = 0; checksum=0; counters=0.
- Reset mid-frame aborts the frame. No error pulse is generated.
- FSM states and transitions:
  - IDLE: accepted byte == SYNC_BYTE -> clear payload register, checksum=0, go to CMD. Any other byte is discarded.
  - CMD: store cmd_out, checksum=byte, go to LEN.
  - LEN: if byte > MAX_LEN -> pulse err_length, go to IDLE. Otherwise store len_out, checksum^=byte, idx=0. If len==0 go to CHECK, else go to PAYLOAD.
  - PAYLOAD: store byte at index idx, checksum^=byte, idx++. After accepting byte len-1, go to CHECK.
  - CHECK: if byte == checksum -> go to HOLD, out_valid=1 next cycle. Otherwise pulse err_checksum, go to IDLE.
  - HOLD: out_valid=1; cmd_out, len_out and payload_out held stable. When out_ready=1, go to IDLE; out_valid drops the following cycle.
- Latency: out_valid rises 1 cycle after the checksum byte is accepted.
- Checksum: 8-bit XOR of cmd, len and payload bytes. SYNC_BYTE is excluded.
- Sync handling: SYNC_BYTE seen inside a frame is plain data. There is no resync mid-frame.
- Timeout:
  - Applies in CMD, LEN, PAYLOAD and CHECK only.
  - Counter clears on every accepted byte and on entry to CMD.
  - When the counter reaches TIMEOUT_CYCLES-1 with no byte accepted: pulse err_timeout, go to IDLE.
  - A byte accepted in the same cycle the counter expires wins; no timeout is raised.
- Error pulses last exactly 1 cycle. At most one error pulse per frame.
- HOLD with out_ready=1 and in_valid=1 in the same cycle: no byte is accepted (in_ready=0). The byte is accepted in IDLE on the next cycle.
- Payload bytes beyond len_out read as 0.

Test Plan:
- Good frame: AA 10 02 05 06 11 -> out_valid=1, cmd_out=0x10, len_out=2, payload_out[15:0]=0x0605, upper bytes 0, no error pulses.
- Zero length, with leading garbage: 55 AA 20 00 20 -> 0x55 discarded; cmd_out=0x20, len_out=0, payload_out=0, out_valid=1.
- Bad checksum: AA 10 01 33 00 (expected checksum 0x22) -> single err_checksum pulse, out_valid stays 0. A following good frame is then parsed correctly.
- Length overflow: AA 10 09 -> err_length pulse right after the length byte, state returns to IDLE. A following AA 30 00 30 yields cmd_out=0x30.
- Timeout: with TIMEOUT_CYCLES=100, send AA 10 then idle 100 cycles -> exactly one err_timeout pulse. Then AA 10 00 10 yields out_valid.
- Backpressure and reset:
  - Hold out_ready=0 for 20 cycles after out_valid rises -> in_ready=0 and outputs stable throughout. out_ready=1 -> out_valid falls the next cycle.
  - Assert rst after AA 10 02 05 -> all outputs 0, no error pulse. A new frame after release parses correctly.
